// File: rtl/gpu_spi_host_tx_if.sv
`default_nettype none
// ============================================================================
// gpu_spi_host_tx_if : byte stream in / SPI mode-0 out bundle (MISO set via SPI_TX_MISO_EN)
// Rev 1.0
// ============================================================================
interface gpu_spi_host_tx_if;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        spi_cs_n;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        busy;
  logic [15:0] frames_sent;
`ifdef SPI_TX_MISO_EN
  logic        spi_miso;
  logic [7:0]  rx_data;
  logic        rx_valid;

  modport master (
    output s_valid, s_data, spi_miso,
    input  s_ready, spi_cs_n, spi_sclk, spi_mosi, busy, frames_sent, rx_data, rx_valid
  );
  modport slave (
    input  s_valid, s_data, spi_miso,
    output s_ready, spi_cs_n, spi_sclk, spi_mosi, busy, frames_sent, rx_data, rx_valid
  );
`else
  modport master (
    output s_valid, s_data,
    input  s_ready, spi_cs_n, spi_sclk, spi_mosi, busy, frames_sent
  );
  modport slave (
    input  s_valid, s_data,
    output s_ready, spi_cs_n, spi_sclk, spi_mosi, busy, frames_sent
  );
`endif
endinterface
`default_nettype wire

// File: rtl/gpu_spi_host_tx.sv
`default_nettype none
// ============================================================================
// gpu_spi_host_tx : FIFO-buffered SPI mode-0 master, fixed-length cs_n frames; SPI_TX_MISO_EN adds RX
// Rev 1.0
// ============================================================================
module gpu_spi_host_tx #(
  parameter int CLK_DIV     = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int FRAME_BYTES = 6,
  parameter int CS_GAP      = 2
) (
  input wire                 clk,
  input wire                 rst_n,
  gpu_spi_host_tx_if.slave   bus
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int BCW  = $clog2(FRAME_BYTES + 1);
  localparam int DMAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int DW   = $clog2(DMAX + 1);

  localparam logic [DW-1:0]  DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]  GAP_LAST  = DW'(CS_GAP - 1);
  localparam logic [BCW-1:0] BYTE_LAST = BCW'(FRAME_BYTES - 1);
  localparam logic [AW:0]    FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_GAP   = 3'd5
  } state_e;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q, rd_nxt, cnt;
  logic        empty, full, push, pop;
  logic [7:0]  head, next_head;

  assign cnt       = wr_q - rd_q;
  assign empty     = (cnt == '0);
  assign full      = (cnt == FULL_CNT);
  assign push      = bus.s_valid && !full;
  assign rd_nxt    = rd_q + 1'b1;
  assign head      = mem_q[rd_q[AW-1:0]];
  assign next_head = mem_q[rd_nxt[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= bus.s_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_nxt;
    end
  end

  // ---------------------------------------------------------------- FSM
  state_e         state_q, state_d;
  logic [DW-1:0]  div_q, div_d;
  logic [2:0]     bit_q, bit_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic           cs_n_q, cs_n_d;
  logic           sclk_q, sclk_d;
  logic           mosi_q, mosi_d;
  logic [15:0]    frames_q, frames_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      bcnt_q   <= '0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      bcnt_q   <= bcnt_d;
      cs_n_q   <= cs_n_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      frames_q <= frames_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    bcnt_d   = bcnt_q;
    cs_n_d   = cs_n_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    frames_d = frames_q;
    pop      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          cs_n_d  = 1'b0;
          mosi_d  = head[7];
          div_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          sclk_d  = 1'b1;
          state_d = ST_SHIFT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            // Falling edge: either the next bit of this byte, or a byte boundary.
            if (bit_q == 3'd7) begin
              pop    = 1'b1;
              bit_d  = '0;
              bcnt_d = bcnt_q + 1'b1;
              if (bcnt_q == BYTE_LAST) begin
                state_d = ST_HOLD;
              end else if (cnt > (AW + 1)'(1)) begin
                mosi_d = next_head[7];
              end else begin
                state_d = ST_WAIT;
              end
            end else begin
              bit_d  = bit_q + 1'b1;
              mosi_d = head[3'd6 - bit_q];
            end
          end
        end
      end
      ST_WAIT: begin
        if (!empty) begin
          mosi_d  = head[7];
          div_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_HOLD: begin
        if (div_q == DIV_LAST) begin
          div_d    = '0;
          cs_n_d   = 1'b1;
          mosi_d   = 1'b0;
          bcnt_d   = '0;
          frames_d = frames_q + 16'd1;
          state_d  = ST_GAP;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (div_q == GAP_LAST) begin
          div_d   = '0;
          state_d = ST_IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.s_ready     = !full;
  assign bus.spi_cs_n    = cs_n_q;
  assign bus.spi_sclk    = sclk_q;
  assign bus.spi_mosi    = mosi_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.frames_sent = frames_q;

`ifdef SPI_TX_MISO_EN
  // MISO is captured on the same clk edge that raises sclk; bit_q then holds the bit index.
  logic       rise;
  logic [7:0] rx_sh_q, rx_data_q;
  logic       rx_valid_q;

  assign rise = sclk_d && !sclk_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (rise) begin
        rx_sh_q <= {rx_sh_q[6:0], bus.spi_miso};
        if (bit_q == 3'd7) begin
          rx_data_q  <= {rx_sh_q[6:0], bus.spi_miso};
          rx_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
`endif

endmodule
`default_nettype wire
